// File: rtl/fetch_stage.sv
// Instruction fetch stage: program-load memory, PC sequencing with jump/branch
// redirects, halt detection and a LOAD/RUN/HALTED control FSM.
module fetch_stage #(
    parameter int unsigned        NB_PC     = 32,
    parameter int unsigned        NB_INST   = 32,
    parameter int unsigned        N_WORDS   = 64,
    parameter logic [NB_INST-1:0] HALT_INST = NB_INST'(32'hFFFFFFFF)
) (
    input  logic                       i_clock,
    input  logic                       i_IF_reset,
    input  logic                       i_IF_enable,
    input  logic                       i_IF_start,
    input  logic                       i_IF_wr_en,
    input  logic [$clog2(N_WORDS)-1:0] i_IF_wr_addr,
    input  logic [NB_INST-1:0]         i_IF_wr_data,
    input  logic                       i_IF_jump,
    input  logic [NB_PC-1:0]           i_IF_jump_addr,
    input  logic                       i_IF_branch,
    input  logic [NB_PC-1:0]           i_IF_branch_addr,
    output logic [NB_INST-1:0]         o_IF_inst,
    output logic [NB_PC-1:0]           o_IF_pc,
    output logic                       o_IF_halt,
    output logic                       o_IF_running
);

    localparam int unsigned NB_ADDR = $clog2(N_WORDS);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [NB_PC-1:0]   pc, pc_next, pc_out, pc_out_next, pc_inc, target;
    logic [NB_INST-1:0] inst, inst_next, fetch_word;
    logic               halt, halt_next, running;

    logic [NB_INST-1:0] imem [N_WORDS];

    assign pc_inc     = pc + NB_PC'(4);
    assign fetch_word = imem[pc[NB_ADDR+1:2]];
    // Jump wins over branch; targets are forced word-aligned.
    assign target     = (i_IF_jump ? i_IF_jump_addr : i_IF_branch_addr) & ~NB_PC'(3);

    // Program memory is deliberately not reset so a loaded program survives reset.
    always_ff @(posedge i_clock) begin
        if (state == LOAD && i_IF_wr_en && !i_IF_reset) begin
            imem[i_IF_wr_addr] <= i_IF_wr_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_IF_reset) begin
        if (i_IF_reset) begin
            state   <= LOAD;
            pc      <= '0;
            inst    <= '0;
            pc_out  <= '0;
            halt    <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            inst    <= inst_next;
            pc_out  <= pc_out_next;
            halt    <= halt_next;
            running <= (state_next == RUN);
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        inst_next   = inst;
        pc_out_next = pc_out;
        halt_next   = halt;
        case (state)
            LOAD: begin
                if (i_IF_start) begin
                    state_next = RUN;
                    pc_next    = '0;
                end
            end
            RUN: begin
                if (i_IF_enable) begin
                    if (i_IF_jump || i_IF_branch) begin
                        pc_next     = target;
                        inst_next   = '0;
                        pc_out_next = '0;
                    end else begin
                        inst_next   = fetch_word;
                        pc_out_next = pc_inc;
                        // A halt word is passed to decode but the PC stays on it.
                        if (fetch_word == HALT_INST) begin
                            halt_next  = 1'b1;
                            state_next = HALTED;
                        end else begin
                            pc_next = pc_inc;
                        end
                    end
                end
            end
            HALTED: begin
                if (i_IF_enable) begin
                    inst_next   = '0;
                    pc_out_next = '0;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    assign o_IF_inst    = inst;
    assign o_IF_pc      = pc_out;
    assign o_IF_halt    = halt;
    assign o_IF_running = running;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFFFFFF;
    localparam int M_LOAD = 0, M_RUN = 1, M_HALTED = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en, start, wr_en, jump, branch;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data, jump_addr, branch_addr;
    logic [31:0] inst, pc;
    logic        halt, running;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_mem [64];
    int          m_mode;
    logic [31:0] m_pc, m_inst, m_pco;
    logic        m_halt;

    typedef struct {
        bit          en, start, wr;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        bit          jump;
        logic [31:0] jaddr;
        bit          br;
        logic [31:0] baddr;
        logic [31:0] e_inst, e_pc;
        bit          e_halt, e_run;
    } vec_t;

    vec_t vq[$];

    fetch_stage #(.NB_PC(32), .NB_INST(32), .N_WORDS(64), .HALT_INST(HALT)) dut (
        .i_clock         (clk),
        .i_IF_reset      (rst),
        .i_IF_enable     (en),
        .i_IF_start      (start),
        .i_IF_wr_en      (wr_en),
        .i_IF_wr_addr    (wr_addr),
        .i_IF_wr_data    (wr_data),
        .i_IF_jump       (jump),
        .i_IF_jump_addr  (jump_addr),
        .i_IF_branch     (branch),
        .i_IF_branch_addr(branch_addr),
        .o_IF_inst       (inst),
        .o_IF_pc         (pc),
        .o_IF_halt       (halt),
        .o_IF_running    (running)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string nm, input logic [31:0] e_inst, input logic [31:0] e_pc,
                              input logic e_halt, input logic e_run);
        chk({nm, ".inst"}, inst, e_inst);
        chk({nm, ".pc"}, pc, e_pc);
        chk({nm, ".halt"}, 32'(halt), 32'(e_halt));
        chk({nm, ".running"}, 32'(running), 32'(e_run));
    endtask

    task automatic idle();
        en = 0; start = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
        jump = 0; jump_addr = '0; branch = 0; branch_addr = '0;
    endtask

    function automatic void model_reset();
        m_mode = M_LOAD; m_pc = 0; m_inst = 0; m_pco = 0; m_halt = 0;
    endfunction

    // One rising edge of the fetch rules, expressed on whole-word arithmetic.
    function automatic void model_edge();
        logic [31:0] w;
        if (m_mode == M_LOAD) begin
            if (wr_en) m_mem[wr_addr] = wr_data;
            if (start) begin m_mode = M_RUN; m_pc = 0; end
        end else if (m_mode == M_RUN && en) begin
            if (jump || branch) begin
                m_pc   = (jump ? jump_addr : branch_addr) / 4 * 4;
                m_inst = 0;
                m_pco  = 0;
            end else begin
                w      = m_mem[(m_pc / 4) % 64];
                m_inst = w;
                m_pco  = m_pc + 4;
                if (w == HALT) begin
                    m_halt = 1;
                    m_mode = M_HALTED;
                end else begin
                    m_pc = m_pc + 4;
                end
            end
        end else if (m_mode == M_HALTED && en) begin
            m_inst = 0;
            m_pco  = 0;
        end
    endfunction

    task automatic tick(input bit cmp);
        @(posedge clk);
        model_edge();
        #1;
        if (cmp) expect_out("model", m_inst, m_pco, m_halt, m_mode == M_RUN);
    endtask

    // Reset lands between edges; a write and a start pending under it must be dropped.
    task automatic do_reset(input string nm);
        #2;
        rst = 1;
        wr_en = 1; wr_addr = 6'($urandom_range(0, 63)); wr_data = 32'h0BAD0BAD; start = 1;
        #1;
        model_reset();
        expect_out(nm, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 0;
        idle();
    endtask

    function automatic vec_t mk(bit en_i, bit st, bit wr, logic [5:0] wa, logic [31:0] wd,
                                bit j, logic [31:0] ja, bit b, logic [31:0] ba,
                                logic [31:0] ei, logic [31:0] ep, bit eh, bit er);
        vec_t v;
        v.en = en_i; v.start = st; v.wr = wr; v.waddr = wa; v.wdata = wd;
        v.jump = j; v.jaddr = ja; v.br = b; v.baddr = ba;
        v.e_inst = ei; v.e_pc = ep; v.e_halt = eh; v.e_run = er;
        return v;
    endfunction

    initial begin
        idle();
        do_reset("reset0");

        // Fill every word so nothing in memory is undefined.
        for (int i = 0; i < 64; i++) begin
            wr_en = 1; wr_addr = 6'(i); wr_data = 32'h10000000 + 32'(i);
            tick(1);
        end
        idle();

        vq.push_back(mk(0,0,1, 0, 32'h00221820, 0,0, 0,0,    32'h0,        32'h0,  0,0));
        vq.push_back(mk(0,0,1, 1, 32'h00432022, 0,0, 0,0,    32'h0,        32'h0,  0,0));
        vq.push_back(mk(0,0,1, 2, HALT,         0,0, 0,0,    32'h0,        32'h0,  0,0));
        vq.push_back(mk(0,1,1,16, 32'h0000AAAA, 0,0, 0,0,    32'h0,        32'h0,  0,1));
        vq.push_back(mk(1,0,0, 0, 0,            0,0, 0,0,    32'h00221820, 32'h4,  0,1));
        vq.push_back(mk(0,0,0, 0, 0,            1,32'h43, 0,0, 32'h00221820, 32'h4, 0,1));
        vq.push_back(mk(1,0,0, 0, 0,            1,32'h43, 1,32'h80, 32'h0,  32'h0,  0,1));
        vq.push_back(mk(1,0,0, 0, 0,            0,0, 0,0,    32'h0000AAAA, 32'h44, 0,1));
        vq.push_back(mk(1,0,0, 0, 0,            0,0, 1,0,    32'h0,        32'h0,  0,1));
        vq.push_back(mk(1,0,0, 0, 0,            0,0, 0,0,    32'h00221820, 32'h4,  0,1));
        vq.push_back(mk(1,0,1, 1, 32'hDEADBEEF, 0,0, 0,0,    32'h00432022, 32'h8,  0,1));
        vq.push_back(mk(0,0,0, 0, 0,            0,0, 0,0,    32'h00432022, 32'h8,  0,1));
        vq.push_back(mk(0,1,0, 0, 0,            0,0, 0,0,    32'h00432022, 32'h8,  0,1));
        vq.push_back(mk(0,0,0, 0, 0,            0,0, 0,0,    32'h00432022, 32'h8,  0,1));
        vq.push_back(mk(1,0,0, 0, 0,            0,0, 0,0,    HALT,         32'hC,  1,0));
        vq.push_back(mk(0,0,0, 0, 0,            0,0, 0,0,    HALT,         32'hC,  1,0));
        vq.push_back(mk(1,1,1, 5, 32'h12345678, 1,32'h40, 0,0, 32'h0,      32'h0,  1,0));
        vq.push_back(mk(1,0,0, 0, 0,            0,0, 0,0,    32'h0,        32'h0,  1,0));

        foreach (vq[k]) begin
            en = vq[k].en; start = vq[k].start; wr_en = vq[k].wr;
            wr_addr = vq[k].waddr; wr_data = vq[k].wdata;
            jump = vq[k].jump; jump_addr = vq[k].jaddr;
            branch = vq[k].br; branch_addr = vq[k].baddr;
            tick(0);
            expect_out($sformatf("vec%0d", k), vq[k].e_inst, vq[k].e_pc, vq[k].e_halt, vq[k].e_run);
        end
        idle();

        // Reset out of HALTED; program (with the ignored RUN write) must be intact.
        do_reset("reset_halted");
        start = 1; tick(0); expect_out("restart", 32'h0, 32'h0, 0, 1);
        idle(); en = 1;
        tick(0); expect_out("refetch0", 32'h00221820, 32'h4, 0, 1);
        tick(0); expect_out("refetch1", 32'h00432022, 32'h8, 0, 1);
        en = 0;
        do_reset("reset_midrun");

        // Branch to the last word, then sequential fetch wraps to word 0.
        wr_en = 1; wr_addr = 6'd63; wr_data = 32'h3F3F3F3F; start = 1;
        tick(0); expect_out("wrap_start", 32'h0, 32'h0, 0, 1);
        idle(); en = 1; branch = 1; branch_addr = 32'hFC;
        tick(0); expect_out("wrap_branch", 32'h0, 32'h0, 0, 1);
        idle(); en = 1;
        tick(0); expect_out("wrap_w63", 32'h3F3F3F3F, 32'h100, 0, 1);
        tick(0); expect_out("wrap_w0", 32'h00221820, 32'h104, 0, 1);
        tick(0); expect_out("wrap_w1", 32'h00432022, 32'h108, 0, 1);
        tick(0); expect_out("wrap_halt", HALT, 32'h10C, 1, 0);
        tick(0); expect_out("halt_nop", 32'h0, 32'h0, 1, 0);
        idle();

        // Randomized traffic checked against the model every cycle.
        do_reset("reset_rand");
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset("reset_r");
            end else begin
                en          = ($urandom_range(0, 3) != 0);
                start       = (m_mode == M_LOAD) ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
                wr_en       = 1'($urandom_range(0, 1));
                wr_addr     = 6'($urandom_range(0, 63));
                wr_data     = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
                jump        = ($urandom_range(0, 9) == 0);
                jump_addr   = $urandom;
                branch      = ($urandom_range(0, 9) == 0);
                branch_addr = $urandom;
                tick(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameters: NB_PC, default 32, PC width; NB_INST, default 32, instruction width; N_WORDS, default 64, instruction memory depth in words (power of 2); HALT_INST, default 32'hFFFFFFFF, halt encoding.
REQ-002 SHALL have ports, in this order:
- i_clock  in  1  sole clock; all state updates on its rising edge.
- i_IF_reset  in  1  asynchronous, active-high reset.
- i_IF_enable  in  1  advance; 0 = stall.
- i_IF_start  in  1  leave LOAD, begin fetching.
- i_IF_wr_en  in  1  program-load write strobe.
- i_IF_wr_addr  in  log2(N_WORDS)  program-load word address.
- i_IF_wr_data  in  NB_INST  program-load word.
- i_IF_jump  in  1  jump redirect from decode.
- i_IF_jump_addr  in  NB_PC  jump target.
- i_IF_branch  in  1  taken-branch redirect.
- i_IF_branch_addr  in  NB_PC  branch target.
- o_IF_inst  out  NB_INST  registered instruction to decode.
- o_IF_pc  out  NB_PC  registered PC+4 of o_IF_inst.
- o_IF_halt  out  1  halt instruction fetched.
- o_IF_running  out  1  state == RUN.

Function
REQ-003 SHALL implement a 3-state FSM: LOAD, RUN, HALTED.
REQ-004 LOAD: i_IF_wr_en=1 SHALL write i_IF_wr_data to imem[i_IF_wr_addr] at the clock edge; PC, o_IF_inst and o_IF_pc hold.
REQ-005 LOAD with i_IF_start=1 SHALL transition to RUN on the next edge, PC=0; a write in the same cycle SHALL still be performed.
REQ-006 i_IF_wr_en SHALL be ignored in RUN and HALTED.
REQ-007 RUN with i_IF_enable=0 SHALL hold PC, o_IF_inst, o_IF_pc, o_IF_halt and state unchanged; redirects that cycle SHALL be ignored.
REQ-008 RUN with i_IF_enable=1 and no redirect SHALL register o_IF_inst=imem[PC[log2(N_WORDS)+1:2]], o_IF_pc=PC+4, and update PC=PC+4 (1-cycle fetch latency).
REQ-009 Word index SHALL use only PC bits [log2(N_WORDS)+1:2]; PC beyond the memory wraps modulo N_WORDS words; PC arithmetic SHALL wrap modulo 2^NB_PC.
REQ-010 Redirect priority SHALL be jump > branch > PC+4; with i_IF_enable=1 and a redirect, PC SHALL load the target with bits [1:0] forced to 00, o_IF_inst SHALL be 32'h00000000 (NOP flush), and o_IF_pc SHALL be 0.
REQ-011 i_IF_jump and i_IF_branch both high SHALL select jump_addr.
REQ-012 When the fetched word equals HALT_INST with no redirect, SHALL register o_IF_inst=HALT_INST, o_IF_pc=PC+4, o_IF_halt=1, leave PC unchanged, and enter HALTED; a redirect in that cycle takes precedence (flush, no halt).
REQ-013 HALTED SHALL output o_IF_inst=NOP and o_IF_pc=0 from the next enabled cycle onward, keep o_IF_halt=1, freeze PC, and ignore start, redirects and writes; it SHALL exit only via reset.
REQ-014 o_IF_running SHALL be 1 exactly in RUN (registered state, no combinational path from inputs).
REQ-015 i_IF_start outside LOAD SHALL have no effect.

Reset
REQ-016 i_IF_reset=1 SHALL immediately, independent of i_clock, set state=LOAD, PC=0, o_IF_inst=0, o_IF_pc=0, o_IF_halt=0, o_IF_running=0.
REQ-017 Reset SHALL NOT clear imem; a loaded program SHALL survive reset, including reset asserted mid-RUN or in HALTED.
REQ-018 Operations pending when reset asserts (write, redirect, start) SHALL be discarded.

Verification
REQ-019 Load imem[0..2]={32'h00221820, 32'h00432022, HALT_INST}, start, enable=1 -> o_IF_inst 0x00221820/pc 4, then 0x00432022/pc 8, then HALT_INST/pc 12 with o_IF_halt=1, then NOP, o_IF_running=0.
REQ-020 RUN at PC=8, enable=0 for 3 cycles -> outputs and PC constant; enable=1 resumes with imem[2], o_IF_pc=12.
REQ-021 RUN, jump=1 to 0x00000043 with branch=1 to 0x80 same cycle -> o_IF_inst=NOP, o_IF_pc=0; next o_IF_inst=imem[16], o_IF_pc=0x44.
REQ-022 N_WORDS=64, branch to 0x000000FC then enable -> fetches imem[63] pc 0x100, then imem[0] (wrap) pc 0x104.
REQ-023 Reset asserted asynchronously mid-RUN between edges -> all outputs 0 immediately, state LOAD; start again re-fetches the unchanged program from PC=0.
REQ-024 Write during RUN to imem[1]=32'hDEADBEEF -> ignored; after reset+start, imem[1] returns original word.
